down_count_watch: RTL and testbench

- Downstream monitor for a free-running or enabled down counter, e.g. the 3-bit down counter (q resets to 7, decrements each clk).
- Samples the counter value, locks onto the decrementing sequence and flags sequence violations.
- Emits a terminal-count pulse on each accepted 0 and counts wrap-arounds (0 -> max).
- Used as a checker in front of logic that consumes counter terminal events.

---
 rtl/down_count_watch_if.sv | 38 +++
 rtl/down_count_watch.sv | 156 +++++++++++++++
 tb/tb_down_count_watch.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/down_count_watch_if.sv
// Bus between a down-counter source and the down_count_watch checker.
// Define DOWN_COUNT_WATCH_SNAPSHOT_EN to add the err_exp/err_got snapshot signals.
interface down_count_watch_if #(
  parameter int WIDTH  = 3,
  parameter int WRAP_W = 8
);
  logic              en;
  logic [WIDTH-1:0]  q_in;
  logic              clr_err;
  logic              locked;
  logic              tc_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              seq_err;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
  logic [WIDTH-1:0]  err_exp;
  logic [WIDTH-1:0]  err_got;

  modport master (
    output en, q_in, clr_err,
    input  locked, tc_pulse, wrap_cnt, seq_err, err_exp, err_got
  );

  modport slave (
    input  en, q_in, clr_err,
    output locked, tc_pulse, wrap_cnt, seq_err, err_exp, err_got
  );
`else
  modport master (
    output en, q_in, clr_err,
    input  locked, tc_pulse, wrap_cnt, seq_err
  );

  modport slave (
    input  en, q_in, clr_err,
    output locked, tc_pulse, wrap_cnt, seq_err
  );
`endif
endinterface

// File: rtl/down_count_watch.sv
// Locks onto a decrementing counter, pulses on terminal count, counts wraps, flags violations.
// Define DOWN_COUNT_WATCH_SNAPSHOT_EN to capture expected/observed values on fault entry.
module down_count_watch #(
  parameter int WIDTH     = 3,
  parameter int WRAP_W    = 8,
  parameter int ERR_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  down_count_watch_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TRACK,
    ST_FAULT
  } state_e;

  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};
  localparam logic [WIDTH-1:0]  Q_MAX    = {WIDTH{1'b1}};
  localparam logic [3:0]        MIS_LIM  = 4'(ERR_LIMIT);

  state_e            state_q,    state_d;
  logic [WIDTH-1:0]  prev_q,     prev_d;
  logic [3:0]        mis_cnt_q,  mis_cnt_d;
  logic              locked_q,   locked_d;
  logic              tc_pulse_q, tc_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              seq_err_q,  seq_err_d;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
  logic [WIDTH-1:0]  err_exp_q,  err_exp_d;
  logic [WIDTH-1:0]  err_got_q,  err_got_d;
`endif

  logic [WIDTH-1:0]  exp_val;
  logic              match;

  // Modulo subtraction gives 0 - 1 = max for free.
  assign exp_val = prev_q - WIDTH'(1);
  assign match   = (bus.q_in == exp_val);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    prev_d     = prev_q;
    mis_cnt_d  = mis_cnt_q;
    locked_d   = locked_q;
    tc_pulse_d = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    seq_err_d  = seq_err_q;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          prev_d  = bus.q_in;
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (bus.en) begin
          prev_d = bus.q_in;
          if (match) begin
            state_d  = ST_TRACK;
            locked_d = 1'b1;
          end
        end
      end

      ST_TRACK: begin
        if (bus.en) begin
          // Mismatches resync to the observed value so one glitch costs one error.
          prev_d = bus.q_in;
          if (match) begin
            mis_cnt_d  = 4'd0;
            tc_pulse_d = (bus.q_in == '0);
            if ((prev_q == '0) && (bus.q_in == Q_MAX) && (wrap_cnt_q != WRAP_MAX)) begin
              wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
            end
          end else begin
            mis_cnt_d = mis_cnt_q + 4'd1;
            if (mis_cnt_d == MIS_LIM) begin
              state_d   = ST_FAULT;
              locked_d  = 1'b0;
              seq_err_d = 1'b1;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
              err_exp_d = exp_val;
              err_got_d = bus.q_in;
`endif
            end
          end
        end
      end

      ST_FAULT: begin
        if (bus.clr_err) begin
          state_d   = ST_IDLE;
          seq_err_d = 1'b0;
          mis_cnt_d = 4'd0;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
          err_exp_d = '0;
          err_got_d = '0;
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= '0;
      mis_cnt_q  <= 4'd0;
      locked_q   <= 1'b0;
      tc_pulse_q <= 1'b0;
      wrap_cnt_q <= '0;
      seq_err_q  <= 1'b0;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
      err_exp_q  <= '0;
      err_got_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      mis_cnt_q  <= mis_cnt_d;
      locked_q   <= locked_d;
      tc_pulse_q <= tc_pulse_d;
      wrap_cnt_q <= wrap_cnt_d;
      seq_err_q  <= seq_err_d;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
`endif
    end
  end

  assign bus.locked   = locked_q;
  assign bus.tc_pulse = tc_pulse_q;
  assign bus.wrap_cnt = wrap_cnt_q;
  assign bus.seq_err  = seq_err_q;
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
  assign bus.err_exp  = err_exp_q;
  assign bus.err_got  = err_got_q;
`endif

endmodule

// File: tb/tb_down_count_watch.sv
// Directed bench for down_count_watch: per-cycle model compare plus hand-computed checkpoints.
module tb_down_count_watch;

  localparam int WIDTH     = 3;
  localparam int WRAP_W    = 8;
  localparam int ERR_LIMIT = 2;
  localparam int QMOD      = 1 << WIDTH;
  localparam int WRAP_SAT  = (1 << WRAP_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;

  down_count_watch_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

  down_count_watch #(
    .WIDTH    (WIDTH),
    .WRAP_W   (WRAP_W),
    .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: what each rule says should be visible after the edge.
  bit m_seen, m_locked, m_fault, m_tc;
  int m_prev, m_miss, m_wrap, m_exp_snap, m_got_snap;

  always @(posedge clk) begin
    int want_next;
    if (rst) begin
      m_seen = 0; m_locked = 0; m_fault = 0; m_tc = 0;
      m_prev = 0; m_miss = 0; m_wrap = 0; m_exp_snap = 0; m_got_snap = 0;
    end else begin
      m_tc = 0;
      if (m_fault) begin
        if (bus.clr_err) begin
          m_fault = 0; m_seen = 0; m_miss = 0; m_exp_snap = 0; m_got_snap = 0;
        end
      end else if (bus.en) begin
        want_next = (m_prev + QMOD - 1) % QMOD;
        if (!m_seen) begin
          m_seen = 1;
        end else if (!m_locked) begin
          if (int'(bus.q_in) == want_next) m_locked = 1;
        end else if (int'(bus.q_in) == want_next) begin
          m_miss = 0;
          if (bus.q_in == 0) m_tc = 1;
          if (m_prev == 0 && m_wrap < WRAP_SAT) m_wrap++;
        end else begin
          m_miss++;
          if (m_miss == ERR_LIMIT) begin
            m_locked = 0; m_fault = 1;
            m_exp_snap = want_next; m_got_snap = int'(bus.q_in);
          end
        end
        m_prev = int'(bus.q_in);
      end
    end
  end

  always @(negedge clk) begin
    check("model_locked",   int'(bus.locked),   int'(m_locked));
    check("model_tc_pulse", int'(bus.tc_pulse), int'(m_tc));
    check("model_wrap_cnt", int'(bus.wrap_cnt), m_wrap);
    check("model_seq_err",  int'(bus.seq_err),  int'(m_fault));
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
    check("model_err_exp",  int'(bus.err_exp),  m_exp_snap);
    check("model_err_got",  int'(bus.err_got),  m_got_snap);
`endif
  end

  // Inputs change on the falling edge; returns at the next falling edge with outputs settled.
  task automatic step(input bit e, input int q, input bit c);
    bus.en      = e;
    bus.q_in    = WIDTH'(q);
    bus.clr_err = c;
    @(negedge clk);
  endtask

  task automatic full_cycle();
    for (int v = 5; v >= 0; v--) step(1, v, 0);
    step(1, 7, 0);
    step(1, 6, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},   int'(bus.locked),   0);
    check({tag, "_tc_pulse"}, int'(bus.tc_pulse), 0);
    check({tag, "_wrap_cnt"}, int'(bus.wrap_cnt), 0);
    check({tag, "_seq_err"},  int'(bus.seq_err),  0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en = 1'b0; bus.q_in = '0; bus.clr_err = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    step(0, 0, 0);
    step(0, 0, 0);
    check_all_zero("reset");
    rst = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    check_all_zero("idle_en0");

    // Lock on 7,6,5
    step(1, 7, 0);
    check("lock_after7", int'(bus.locked), 0);
    step(1, 6, 0);
    check("lock_after6", int'(bus.locked), 1);
    step(1, 5, 0);
    check("lock_after5", int'(bus.locked), 1);
    check("lock_seq_err", int'(bus.seq_err), 0);

    // Gap of three idle cycles with a bogus q_in
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      check("gap_locked", int'(bus.locked), 1);
      check("gap_tc", int'(bus.tc_pulse), 0);
    end
    step(1, 4, 0);
    check("gap_resume_locked", int'(bus.locked), 1);
    check("gap_resume_seq_err", int'(bus.seq_err), 0);

    // Terminal count and first wrap
    step(1, 3, 0);
    step(1, 2, 0);
    step(1, 1, 0);
    check("tc_before0", int'(bus.tc_pulse), 0);
    step(1, 0, 0);
    check("tc_after0", int'(bus.tc_pulse), 1);
    check("wrap_before7", int'(bus.wrap_cnt), 0);
    step(1, 7, 0);
    check("tc_after7", int'(bus.tc_pulse), 0);
    check("wrap_after7", int'(bus.wrap_cnt), 1);
    step(1, 6, 0);
    for (int i = 0; i < 3; i++) full_cycle();
    check("wrap_four", int'(bus.wrap_cnt), 4);

    // One isolated mismatch resyncs without a fault
    step(1, 5, 0);
    step(1, 4, 0);
    step(1, 2, 0);
    check("single_mis_locked", int'(bus.locked), 1);
    check("single_mis_seq_err", int'(bus.seq_err), 0);
    step(1, 1, 0);
    check("resync_locked", int'(bus.locked), 1);

    // Two consecutive mismatches reach the limit
    step(1, 0, 0);
    check("tc_before_fault", int'(bus.tc_pulse), 1);
    step(1, 6, 0);
    check("first_mis_locked", int'(bus.locked), 1);
    check("first_mis_tc", int'(bus.tc_pulse), 0);
    step(1, 3, 0);
    check("fault_seq_err", int'(bus.seq_err), 1);
    check("fault_locked", int'(bus.locked), 0);
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
    check("snap_exp", int'(bus.err_exp), 5);
    check("snap_got", int'(bus.err_got), 3);
`endif

    // FAULT ignores samples, clr_err returns to IDLE keeping wrap_cnt
    step(1, 2, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    check("fault_hold_seq_err", int'(bus.seq_err), 1);
    check("fault_no_tc", int'(bus.tc_pulse), 0);
    step(0, 0, 1);
    check("clr_seq_err", int'(bus.seq_err), 0);
    check("clr_locked", int'(bus.locked), 0);
    check("clr_wrap_kept", int'(bus.wrap_cnt), 4);
`ifdef DOWN_COUNT_WATCH_SNAPSHOT_EN
    check("clr_snap_exp", int'(bus.err_exp), 0);
    check("clr_snap_got", int'(bus.err_got), 0);
`endif

    // clr_err outside FAULT has no effect on relock
    step(1, 7, 1);
    check("relock_after7", int'(bus.locked), 0);
    step(1, 6, 1);
    check("relock_after6", int'(bus.locked), 1);

    // Saturate the wrap counter
    for (int i = 0; i < WRAP_SAT; i++) full_cycle();
    check("wrap_saturated", int'(bus.wrap_cnt), WRAP_SAT);

    // Reset mid-operation with wrap_cnt = 3
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(1, 7, 0);
    step(1, 6, 0);
    for (int i = 0; i < 3; i++) full_cycle();
    check("pre_rst_wrap", int'(bus.wrap_cnt), 3);
    check("pre_rst_locked", int'(bus.locked), 1);
    rst = 1'b1;
    step(1, 5, 0);
    check_all_zero("mid_rst");
    rst = 1'b0;
    step(1, 7, 0);
    check("post_rst_after7", int'(bus.locked), 0);
    step(1, 6, 0);
    check("post_rst_after6", int'(bus.locked), 1);
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
